// File: rtl/tlcd_row_engine.sv
// Character-LCD row engine: runs the HD44780-style init sequence after power-up
// and refreshes the selected rows from a text buffer snapshotted on START.
module tlcd_row_engine #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int E_PULSE    = 200,
  parameter int EXEC_TIME  = 1000,
  parameter int CLEAR_TIME = 2000,
  parameter int INIT_DELAY = 20000,
  parameter int CNT_W      = 20
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic [ROWS-1:0]        ROW_MASK,
  input  logic                   REINIT,
  input  logic [ROWS*COLS*8-1:0] TEXT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   INIT_OK,
  output logic                   TLCD_E,
  output logic                   TLCD_RS,
  output logic                   TLCD_RW,
  output logic [7:0]             TLCD_DATA
);
  localparam int TW = ROWS * COLS * 8;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] E_LEN      = CNT_W'(E_PULSE);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_TIME);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME);

  if (COLS < 1 || COLS > 40 || ROWS < 1 || ROWS > 4 || E_PULSE < 1 || INIT_DELAY < 1 ||
      E_PULSE >= EXEC_TIME || EXEC_TIME > CLEAR_TIME ||
      longint'(CLEAR_TIME) >= (longint'(1) << CNT_W) ||
      longint'(INIT_DELAY) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("tlcd_row_engine: illegal parameter combination");
  end

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ROW_ADDR, ROW_CHAR, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       init_idx;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [TW-1:0]    snap_text;
  logic [ROWS-1:0]  snap_mask;
  logic             run_rows;
  logic             pending;

  state_t           nxt_state;
  logic [2:0]       nxt_idx;
  logic [RW-1:0]    nxt_row;
  logic [CW-1:0]    nxt_col;
  logic [7:0]       nxt_data;
  logic             nxt_rs;
  logic             found;
  logic [RW-1:0]    found_row;
  int               search_from;
  int               char_idx;
  logic [CNT_W-1:0] lim;

  assign TLCD_RW = 1'b0;
  assign lim = (!TLCD_RS && TLCD_DATA == 8'h01) ? CLEAR_LAST : EXEC_LAST;

  // Work out which transaction follows the current one (or the pending dispatch).
  always_comb begin
    search_from = (state == ROW_CHAR) ? int'(row) + 1 : 0;
    found       = 1'b0;
    found_row   = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (snap_mask[r] && r >= search_from) begin
        found     = 1'b1;
        found_row = RW'(r);
      end
    end

    nxt_state = state;
    nxt_idx   = init_idx;
    nxt_row   = row;
    nxt_col   = col;
    case (state)
      INIT: begin
        if (init_idx != 3'd5) begin
          nxt_idx = init_idx + 3'd1;
        end else if (!run_rows) begin
          nxt_state = IDLE;
        end else if (found) begin
          nxt_state = ROW_ADDR;
          nxt_row   = found_row;
        end else begin
          nxt_state = FINISH;
        end
      end
      ROW_ADDR: begin
        if (!pending) begin
          nxt_state = ROW_CHAR;
          nxt_col   = '0;
        end else if (found) begin
          nxt_row = found_row;
        end else begin
          nxt_state = FINISH;
        end
      end
      ROW_CHAR: begin
        if (int'(col) != COLS - 1) begin
          nxt_col = col + CW'(1);
        end else if (found) begin
          nxt_state = ROW_ADDR;
          nxt_row   = found_row;
        end else begin
          nxt_state = FINISH;
        end
      end
      default: ;
    endcase

    char_idx = ROWS * COLS - 1 - (int'(nxt_row) * COLS + int'(nxt_col));
    nxt_rs   = 1'b0;
    nxt_data = 8'h00;
    case (nxt_state)
      INIT: begin
        case (nxt_idx)
          3'd3:    nxt_data = 8'h0C;
          3'd4:    nxt_data = 8'h06;
          3'd5:    nxt_data = 8'h01;
          default: nxt_data = 8'h38;
        endcase
      end
      ROW_ADDR: begin
        case (int'(nxt_row))
          1:       nxt_data = 8'hC0;
          2:       nxt_data = 8'h94;
          3:       nxt_data = 8'hD4;
          default: nxt_data = 8'h80;
        endcase
      end
      ROW_CHAR: begin
        nxt_rs   = 1'b1;
        nxt_data = 8'(snap_text >> (char_idx * 8));
      end
      default: ;
    endcase
  end

  // cnt indexes the cycle within a transaction: 0 is setup, 1..E_PULSE is E high,
  // and the transaction ends when cnt reaches the exec/clear time.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= PWRUP;
      cnt       <= '0;
      init_idx  <= '0;
      row       <= '0;
      col       <= '0;
      snap_text <= '0;
      snap_mask <= '0;
      run_rows  <= 1'b0;
      pending   <= 1'b0;
      BUSY      <= 1'b1;
      DONE      <= 1'b0;
      INIT_OK   <= 1'b0;
      TLCD_E    <= 1'b0;
      TLCD_RS   <= 1'b0;
      TLCD_DATA <= 8'h00;
    end else begin
      DONE <= 1'b0;
      case (state)
        PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt       <= '0;
            state     <= INIT;
            init_idx  <= '0;
            run_rows  <= 1'b0;
            TLCD_RS   <= 1'b0;
            TLCD_DATA <= 8'h38;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (START) begin
            snap_text <= TEXT;
            snap_mask <= ROW_MASK;
            run_rows  <= 1'b1;
            BUSY      <= 1'b1;
            cnt       <= '0;
            if (REINIT) begin
              state     <= INIT;
              init_idx  <= '0;
              pending   <= 1'b0;
              TLCD_RS   <= 1'b0;
              TLCD_DATA <= 8'h38;
            end else begin
              state   <= ROW_ADDR;
              pending <= 1'b1;
            end
          end
        end
        FINISH: state <= IDLE;
        INIT, ROW_ADDR, ROW_CHAR: begin
          if (pending || cnt == lim) begin
            cnt       <= '0;
            TLCD_E    <= 1'b0;
            pending   <= 1'b0;
            state     <= nxt_state;
            init_idx  <= nxt_idx;
            row       <= nxt_row;
            col       <= nxt_col;
            TLCD_RS   <= nxt_rs;
            TLCD_DATA <= nxt_data;
            if (state == INIT && init_idx == 3'd5) INIT_OK <= 1'b1;
            if (nxt_state == IDLE || nxt_state == FINISH) begin
              BUSY <= 1'b0;
              DONE <= (nxt_state == FINISH);
            end
          end else begin
            cnt    <= cnt + 1'b1;
            TLCD_E <= (cnt < E_LEN);
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_tlcd_row_engine.sv
// Scoreboard bench for tlcd_row_engine: a byte-level reference model queues the
// expected LCD transactions and DONE events; monitors pop and compare them.
module tb_tlcd_row_engine;
  localparam int COLS       = 4;
  localparam int ROWS       = 2;
  localparam int E_PULSE    = 2;
  localparam int EXEC_TIME  = 5;
  localparam int CLEAR_TIME = 8;
  localparam int INIT_DELAY = 10;
  localparam int CNT_W      = 20;
  localparam int TW         = ROWS * COLS * 8;
  localparam logic [7:0] INIT_SEQ [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  typedef struct {
    logic       first;
    logic       rs;
    logic [7:0] data;
  } xact_t;

  logic            CLK = 1'b0;
  logic            RESETN = 1'b0;
  logic            START = 1'b0;
  logic            REINIT = 1'b0;
  logic [ROWS-1:0] ROW_MASK = '0;
  logic [TW-1:0]   TEXT = '0;
  logic            BUSY, DONE, INIT_OK, TLCD_E, TLCD_RS, TLCD_RW;
  logic [7:0]      TLCD_DATA;

  xact_t exp_q[$];
  int    done_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    rise_count = 0;
  int    last_rise = 0;
  int    high_len = 0;
  logic  e_prev = 1'b0;
  logic  have_prev = 1'b0;
  logic  prev_clear = 1'b0;
  logic  prev_rs = 1'b0;
  logic  hold_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] hold_data = 8'h00;

  tlcd_row_engine #(
    .COLS(COLS), .ROWS(ROWS), .E_PULSE(E_PULSE), .EXEC_TIME(EXEC_TIME),
    .CLEAR_TIME(CLEAR_TIME), .INIT_DELAY(INIT_DELAY), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .ROW_MASK(ROW_MASK), .REINIT(REINIT),
    .TEXT(TEXT), .BUSY(BUSY), .DONE(DONE), .INIT_OK(INIT_OK), .TLCD_E(TLCD_E),
    .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_init(inout logic first);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back('{first, 1'b0, INIT_SEQ[k]});
      first = 1'b0;
    end
  endfunction

  // Reference model: the byte stream a refresh must produce, plus its DONE timing.
  function automatic void model_refresh(input logic [ROWS-1:0] mask, input logic [TW-1:0] text,
                                        input logic reinit);
    logic first = 1'b1;
    int gap = -1;
    logic [7:0] ch;
    if (reinit) begin
      push_init(first);
      gap = CLEAR_TIME;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (mask[r]) begin
        exp_q.push_back('{first, 1'b0, 8'h80 | ROW_BASE[r]});
        first = 1'b0;
        for (int c = 0; c < COLS; c++) begin
          ch = 8'(text >> ((ROWS * COLS - 1 - (r * COLS + c)) * 8));
          exp_q.push_back('{1'b0, 1'b1, ch});
        end
        gap = EXEC_TIME;
      end
    end
    done_q.push_back(gap);
  endfunction

  // Transaction monitor: byte/RS at each E rise, setup cycle, E width, spacing.
  always @(negedge CLK) begin
    xact_t it;
    if (!RESETN) begin
      e_prev    = 1'b0;
      high_len  = 0;
      have_prev = 1'b0;
      prev_rs   = 1'b0;
      prev_data = 8'h00;
    end else begin
      if (TLCD_E && !e_prev) begin
        rise_count++;
        checkOutput("setup_rs", {prev_rs, prev_data}, {TLCD_RS, TLCD_DATA});
        checkOutput("rw_low", TLCD_RW, 1'b0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_e: rs=%0d data=0x%0h, expected no transaction", TLCD_RS, TLCD_DATA);
        end else begin
          it = exp_q.pop_front();
          checkOutput("xact_byte", {TLCD_RS, TLCD_DATA}, {it.rs, it.data});
          if (!it.first && have_prev)
            checkOutput("xact_spacing", cyc - last_rise, (prev_clear ? CLEAR_TIME : EXEC_TIME) + 1);
          prev_clear = (!it.rs && it.data == 8'h01);
        end
        have_prev = 1'b1;
        last_rise = cyc;
        high_len  = 1;
        hold_rs   = TLCD_RS;
        hold_data = TLCD_DATA;
      end else if (TLCD_E) begin
        high_len++;
        checkOutput("xact_stable", {TLCD_RS, TLCD_DATA}, {hold_rs, hold_data});
      end else if (e_prev) begin
        checkOutput("e_width", high_len, E_PULSE);
      end
      e_prev    = TLCD_E;
      prev_rs   = TLCD_RS;
      prev_data = TLCD_DATA;
    end
  end

  // DONE monitor.
  always @(negedge CLK) begin
    int gap;
    if (RESETN && DONE) begin
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: DONE=1, expected 0 (cycle %0d)", cyc);
      end else begin
        gap = done_q.pop_front();
        checkOutput("done_busy_low", BUSY, 1'b0);
        if (gap >= 0) checkOutput("done_gap", cyc - last_rise, gap);
      end
    end
  end

  task automatic wait_done();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (DONE) break;
    end
    checkOutput("done_seen", DONE, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (!BUSY && !DONE) break;
    end
    checkOutput("idle_reached", {BUSY, DONE}, 2'b00);
  endtask

  task automatic applyStimulus(input logic [ROWS-1:0] mask, input logic [TW-1:0] text,
                               input logic reinit);
    model_refresh(mask, text, reinit);
    @(negedge CLK);
    START = 1'b1; ROW_MASK = mask; TEXT = text; REINIT = reinit;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("busy_after_start", BUSY, 1'b1);
    TEXT = {$urandom, $urandom};
    ROW_MASK = ROWS'($urandom);
    REINIT = 1'b0;
    wait_done();
  endtask

  task automatic power_up();
    int n;
    logic first = 1'b1;
    push_init(first);
    @(negedge CLK);
    RESETN = 1'b1;
    for (n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (TLCD_E) break;
    end
    if (n < 11 || n > 12) begin
      fails++;
      $display("[TB] FAIL first_e_rise: after %0d cycles, expected 11..12", n);
    end
    tests++;
    checkOutput("init_ok_during_init", {INIT_OK, BUSY}, 2'b01);
    for (n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (!BUSY) break;
    end
    checkOutput("init_ok_after_init", {INIT_OK, BUSY}, 2'b10);
    checkOutput("clear_gap", cyc - last_rise, CLEAR_TIME);
    checkOutput("init_bytes_consumed", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int target;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_e", TLCD_E, 1'b0);
    checkOutput("reset_rs", TLCD_RS, 1'b0);
    checkOutput("reset_rw", TLCD_RW, 1'b0);
    checkOutput("reset_data", TLCD_DATA, 8'h00);
    checkOutput("reset_busy", BUSY, 1'b1);
    checkOutput("reset_done", DONE, 1'b0);
    checkOutput("reset_init_ok", INIT_OK, 1'b0);
    power_up();

    applyStimulus(2'b11, "ABCDWXYZ", 1'b0);
    wait_idle();
    applyStimulus(2'b10, "ABCDWXYZ", 1'b0);
    wait_idle();

    model_refresh(2'b00, "ABCDWXYZ", 1'b0);
    @(negedge CLK);
    START = 1'b1; ROW_MASK = 2'b00; REINIT = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    checkOutput("mask0_busy", {BUSY, DONE}, 2'b10);
    @(negedge CLK);
    checkOutput("mask0_finish", {BUSY, DONE}, 2'b01);
    @(negedge CLK);
    checkOutput("mask0_done_pulse", DONE, 1'b0);

    model_refresh(2'b11, "ABCDWXYZ", 1'b0);
    model_refresh(2'b11, "0000ZZZZ", 1'b0);
    @(negedge CLK);
    START = 1'b1; ROW_MASK = 2'b11; TEXT = "ABCDWXYZ"; REINIT = 1'b0;
    @(negedge CLK);
    checkOutput("held_start_busy", BUSY, 1'b1);
    TEXT = "0000ZZZZ";
    wait_done();
    for (n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (BUSY) break;
    end
    checkOutput("held_start_restart", BUSY, 1'b1);
    START = 1'b0;
    wait_done();
    wait_idle();

    applyStimulus(2'b11, "HELLOLCD", 1'b1);
    wait_idle();
    applyStimulus(2'b00, "HELLOLCD", 1'b1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(ROWS'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      wait_idle();
    end
    checkOutput("scoreboard_drained", exp_q.size() + done_q.size(), 0);

    target = rise_count + 4;
    model_refresh(2'b11, "ABCDWXYZ", 1'b0);
    @(negedge CLK);
    START = 1'b1; ROW_MASK = 2'b11; TEXT = "ABCDWXYZ";
    @(negedge CLK);
    START = 1'b0;
    for (n = 0; n < 500; n++) begin
      @(negedge CLK);
      #1;
      if (rise_count >= target) break;
    end
    checkOutput("third_char_e_high", TLCD_E, 1'b1);
    RESETN = 1'b0;
    #1;
    checkOutput("reset_mid_e", TLCD_E, 1'b0);
    checkOutput("reset_mid_init_ok", INIT_OK, 1'b0);
    checkOutput("reset_mid_busy", BUSY, 1'b1);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge CLK);
    power_up();
    applyStimulus(2'b01, "WXYZABCD", 1'b0);
    wait_idle();
    checkOutput("final_drained", exp_q.size() + done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
